// File: rtl/sha3_core_arbiter.sv
// Round-robin arbiter sharing one SHA-3 core between two requesters: streams the
// owner's message into the core, returns the digest, then clears the core.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// CLEAR     | core_rst held high for RST_CYCLES cycles
// IDLE      | waiting for a requester; grants round-robin
// STREAM    | owner's words forwarded to the core until the last word
// WAIT_HASH | waiting for core_out_ready, bounded by the watchdog
// DELIVER   | digest offered to the owner until res_ready
module sha3_core_arbiter #(
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [1:0][31:0] req_data,
  input  logic [1:0]       req_last,
  input  logic [1:0][1:0]  req_byte_num,
  output logic [1:0]       req_ready,
  output logic [1:0]       res_valid,
  output logic [511:0]     res_data,
  input  logic [1:0]       res_ready,
  output logic             core_rst,
  output logic [31:0]      core_in,
  output logic             core_in_ready,
  output logic             core_is_last,
  output logic [1:0]       core_byte_num,
  input  logic             core_buffer_full,
  input  logic [511:0]     core_out,
  input  logic             core_out_ready,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [2:0] ST_CLEAR   = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_STREAM  = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_DELIVER = 3'd4;

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]      state_q, state_d;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic [511:0]    res_data_q, res_data_d;
  logic            timeout_err_q, timeout_err_d;

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    res_data_d    = res_data_q;
    timeout_err_d = timeout_err_q;

    core_rst      = 1'b0;
    core_in       = 32'd0;
    core_in_ready = 1'b0;
    core_is_last  = 1'b0;
    core_byte_num = 2'd0;
    req_ready     = 2'b00;
    res_valid     = 2'b00;

    case (state_q)
      ST_CLEAR: begin
        core_rst = 1'b1;
        if (rst_cnt_q == RC_LAST) begin
          rst_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        // On contention the requester that did not win last time gets the core.
        if (req_valid != 2'b00) begin
          if (req_valid == 2'b11) begin
            owner_d = ~last_grant_q;
          end else begin
            owner_d = req_valid[1];
          end
          last_grant_d = owner_d;
          state_d      = ST_STREAM;
        end
      end

      ST_STREAM: begin
        core_in_ready = req_valid[owner_q] & ~core_buffer_full;
        if (core_in_ready) begin
          core_in            = req_data[owner_q];
          core_is_last       = req_last[owner_q];
          core_byte_num      = req_byte_num[owner_q];
          req_ready[owner_q] = 1'b1;
          if (req_last[owner_q]) begin
            wd_cnt_d = '0;
            state_d  = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        // A digest arriving on the watchdog's final cycle still gets delivered.
        if (core_out_ready) begin
          res_data_d = core_out;
          state_d    = ST_DELIVER;
        end else if (wd_cnt_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          rst_cnt_d     = '0;
          state_d       = ST_CLEAR;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end

      ST_DELIVER: begin
        res_valid[owner_q] = 1'b1;
        if (res_ready[owner_q]) begin
          rst_cnt_d = '0;
          state_d   = ST_CLEAR;
        end
      end

      default: begin
        rst_cnt_d = '0;
        state_d   = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_CLEAR;
      rst_cnt_q     <= '0;
      wd_cnt_q      <= '0;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      res_data_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      res_data_q    <= res_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign res_data    = res_data_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha3_core_arbiter.sv
// Directed bench for sha3_core_arbiter with a small behavioural core model.
module tb_sha3_core_arbiter;

  localparam int RST_CYC = 4;
  localparam int TO_CYC  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_data;
  logic [1:0]       req_last;
  logic [1:0][1:0]  req_byte_num;
  logic [1:0]       req_ready;
  logic [1:0]       res_valid;
  logic [511:0]     res_data;
  logic [1:0]       res_ready;
  logic             core_rst;
  logic [31:0]      core_in;
  logic             core_in_ready;
  logic             core_is_last;
  logic [1:0]       core_byte_num;
  logic             core_buffer_full;
  logic [511:0]     core_out;
  logic             core_out_ready;
  logic             busy;
  logic             timeout_err;

  int n_assert = 0;
  int n_fail   = 0;
  int mon_err  = 0;

  int           core_lat;
  logic [511:0] digest;
  logic [7:0]   lat_cnt;
  logic         pending;

  logic [31:0] wlog[$];
  logic        llog[$];
  logic [1:0]  blog[$];

  sha3_core_arbiter #(.RST_CYCLES(RST_CYC), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_byte_num(req_byte_num), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .core_rst(core_rst), .core_in(core_in), .core_in_ready(core_in_ready),
    .core_is_last(core_is_last), .core_byte_num(core_byte_num),
    .core_buffer_full(core_buffer_full), .core_out(core_out),
    .core_out_ready(core_out_ready), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign core_out = digest;

  // Core model: digest appears core_lat cycles after the last word; 0 = never.
  always @(posedge clk) begin
    if (core_rst) begin
      pending        <= 1'b0;
      core_out_ready <= 1'b0;
      lat_cnt        <= 8'd0;
    end else if (core_in_ready && core_is_last) begin
      pending        <= (core_lat != 0);
      lat_cnt        <= 8'(core_lat);
      core_out_ready <= 1'b0;
    end else if (pending) begin
      if (lat_cnt == 8'd1) begin
        core_out_ready <= 1'b1;
        pending        <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 8'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (core_in_ready) begin
      wlog.push_back(core_in);
      llog.push_back(core_is_last);
      blog.push_back(core_byte_num);
    end
  end

  always @(negedge clk) begin
    if (req_ready == 2'b11) mon_err++;
    if ((|req_ready) != core_in_ready) mon_err++;
    if (!core_in_ready && (core_in != 32'd0 || core_is_last || core_byte_num != 2'd0)) mon_err++;
    if (core_rst && (req_ready != 2'b00 || res_valid != 2'b00)) mon_err++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_len(output int n);
    int g = 0;
    while (!core_rst && g < 100) begin @(negedge clk); g++; end
    n = 0;
    while (core_rst && n < 100) begin n++; @(negedge clk); end
  endtask

  task automatic do_reset();
    int n;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_res_valid", res_valid, 2'b00);
    chk("rst_core_in_ready", core_in_ready, 1'b0);
    chk("rst_core_in", core_in, 32'd0);
    chk("rst_res_data", res_data, 512'd0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    reset = 1'b1;
    clear_len(n);
    chk("rst_clear_len", n, RST_CYC);
    chk("rst_idle_busy", busy, 1'b0);
    chk("rst_idle_req_ready", req_ready, 2'b00);
  endtask

  task automatic send_word(input int r, input logic [31:0] d, input logic last, input logic [1:0] bn);
    int n = 0;
    logic ok = 1'b0;
    req_valid[r] = 1'b1; req_data[r] = d; req_last[r] = last; req_byte_num[r] = bn;
    while (n < 200) begin
      @(negedge clk);
      if (req_ready[r]) begin @(posedge clk); #1; ok = 1'b1; break; end
      n++;
    end
    chk("word_accepted", ok, 1'b1);
    req_valid[r] = 1'b0; req_data[r] = 32'd0; req_last[r] = 1'b0; req_byte_num[r] = 2'd0;
  endtask

  task automatic wait_res(input int r);
    int n = 0;
    while (!res_valid[r] && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic accept(input int r);
    @(negedge clk);
    res_ready[r] = 1'b1;
    @(posedge clk); #1;
    res_ready[r] = 1'b0;
  endtask

  task automatic serve(input int r, input logic [511:0] dig);
    int n = 0;
    logic [1:0] e;
    e = 2'b01 << r;
    digest = dig;
    @(negedge clk);
    while (req_ready == 2'b00 && n < 100) begin @(negedge clk); n++; end
    chk("rr_grant", req_ready, e);
    @(posedge clk); #1;
    wait_res(r);
    chk("rr_res_valid", res_valid, e);
    chk("rr_res_data", res_data, dig);
    accept(r);
    chk("rr_res_valid_drop", res_valid, 2'b00);
  endtask

  initial begin
    int n;
    int bad;
    reset = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; req_byte_num = '0;
    res_ready = '0; core_buffer_full = 1'b0; core_lat = 10; digest = '0;

    // Reset release with no requests.
    do_reset();

    // Three-word message from requester 0.
    wlog.delete(); llog.delete(); blog.delete();
    digest = {16{32'hA5A5A5A5}};
    req_valid[0] = 1'b1; req_data[0] = 32'h11111111; req_last[0] = 1'b0;
    #1 chk("grant_cycle_no_xfer", req_ready, 2'b00);
    send_word(0, 32'h11111111, 1'b0, 2'd0);
    send_word(0, 32'h22222222, 1'b0, 2'd0);
    send_word(0, 32'h33333333, 1'b1, 2'd2);
    wait_res(0);
    chk("msg0_res_valid", res_valid, 2'b01);
    chk("msg0_res_data", res_data, {16{32'hA5A5A5A5}});
    chk("msg0_word_count", wlog.size(), 3);
    chk("msg0_w0", wlog[0], 32'h11111111);
    chk("msg0_w1", wlog[1], 32'h22222222);
    chk("msg0_w2", wlog[2], 32'h33333333);
    chk("msg0_last_flags", {llog[0], llog[1], llog[2]}, 3'b001);
    chk("msg0_byte_num", blog[2], 2'd2);
    res_ready[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("deliver_ignore_nonowner", res_valid, 2'b01);
    chk("deliver_busy", busy, 1'b1);
    res_ready[1] = 1'b0;
    accept(0);
    @(negedge clk);
    clear_len(n);
    chk("msg0_clear_len", n, RST_CYC);

    // Backpressure from core_buffer_full for 5 cycles.
    wlog.delete(); llog.delete(); blog.delete();
    digest = {16{32'h0BADF00D}};
    send_word(0, 32'hCAFE0001, 1'b0, 2'd0);
    req_valid[0] = 1'b1; req_data[0] = 32'hCAFE0002; req_last[0] = 1'b0;
    core_buffer_full = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (core_in_ready || req_ready[0]) bad++;
      @(posedge clk);
    end
    #1 core_buffer_full = 1'b0;
    chk("bp_stalled", bad, 0);
    chk("bp_words_during_stall", wlog.size(), 1);
    send_word(0, 32'hCAFE0002, 1'b0, 2'd0);
    send_word(0, 32'hCAFE0003, 1'b1, 2'd3);
    wait_res(0);
    chk("bp_res_data", res_data, {16{32'h0BADF00D}});
    chk("bp_word_count", wlog.size(), 3);
    chk("bp_words", {wlog[0], wlog[1], wlog[2]}, {32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003});
    chk("bp_byte_num", blog[2], 2'd3);
    accept(0);

    // Contention after reset: owners alternate 0, 1, 0.
    do_reset();
    wlog.delete(); llog.delete(); blog.delete();
    req_valid = 2'b11; req_last = 2'b11;
    req_data[0] = 32'hAAAA0000; req_data[1] = 32'hBBBB1111;
    req_byte_num[0] = 2'd1; req_byte_num[1] = 2'd0;
    serve(0, {16{32'h00000001}});
    serve(1, {16{32'h00000002}});
    serve(0, {16{32'h00000003}});
    req_valid = 2'b00; req_last = 2'b00; req_data = '0; req_byte_num = '0;
    chk("rr_order", {wlog[0], wlog[1], wlog[2]}, {32'hAAAA0000, 32'hBBBB1111, 32'hAAAA0000});

    // Watchdog: core never answers.
    core_lat = 0;
    send_word(1, 32'hDEAD0001, 1'b1, 2'd0);
    @(negedge clk);
    chk("to_err_before", timeout_err, 1'b0);
    n = 0; bad = 0;
    while (!core_rst && n < 100) begin
      n++;
      if (res_valid != 2'b00) bad++;
      @(negedge clk);
    end
    chk("to_wait_cycles", n, TO_CYC);
    chk("to_no_res_valid", bad, 0);
    chk("to_err_set", timeout_err, 1'b1);
    clear_len(n);
    chk("to_clear_len", n, RST_CYC);
    core_lat = 10;
    digest = {16{32'h5EED5EED}};
    send_word(0, 32'h12345678, 1'b1, 2'd1);
    wait_res(0);
    chk("to_next_res_valid", res_valid, 2'b01);
    chk("to_next_res_data", res_data, {16{32'h5EED5EED}});
    chk("to_err_sticky", timeout_err, 1'b1);
    accept(0);

    // Reset in the middle of a four-word message.
    send_word(0, 32'h0000AAA1, 1'b0, 2'd0);
    send_word(0, 32'h0000AAA2, 1'b0, 2'd0);
    req_valid[0] = 1'b1; req_data[0] = 32'h0000AAA3;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_core_rst", core_rst, 1'b1);
    chk("mid_rst_req_ready", req_ready, 2'b00);
    chk("mid_rst_core_in_ready", core_in_ready, 1'b0);
    chk("mid_rst_res_valid", res_valid, 2'b00);
    req_valid = 2'b00; req_data = '0;
    do_reset();
    wlog.delete(); llog.delete(); blog.delete();
    digest = {16{32'h600DCAFE}};
    send_word(0, 32'h77770001, 1'b0, 2'd0);
    send_word(0, 32'h77770002, 1'b1, 2'd2);
    wait_res(0);
    chk("fresh_res_valid", res_valid, 2'b01);
    chk("fresh_res_data", res_data, {16{32'h600DCAFE}});
    chk("fresh_words", {wlog[0], wlog[1]}, {32'h77770001, 32'h77770002});
    chk("fresh_word_count", wlog.size(), 2);
    accept(0);
    @(negedge clk);

    chk("monitor_protocol", mon_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
